pitch_smpl_fifo: RTL and testbench

- Downstream consumer of the pitch-side LC DPLL filtered output (lpf value plus its latch strobe).
- Decimates latched pitch samples and buffers them in a small FIFO.
- Exposes the samples to the processor over rbus, so software reads a gap-free pitch stream instead of polling a live register.
- Sits between the pitch DPLL/LPF output and the rbus read mux.

---
 rtl/pitch_smpl_fifo_pkg.sv | 17 +
 rtl/pitch_fifo_mem.sv | 72 +++++++
 rtl/pitch_smpl_fifo.sv | 141 ++++++++++++++
 tb/tb_pitch_smpl_fifo.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/pitch_smpl_fifo_pkg.sv
// Shared constants for the pitch sample FIFO: status/control bit positions
// and the decimation ratio helper.
package pitch_smpl_fifo_pkg;

   localparam int STAT_OVF_B     = 31;
   localparam int STAT_EMPTY_B   = 30;
   localparam int STAT_DEC_LSB   = 8;
   localparam int CTRL_FLUSH_B   = 0;
   localparam int CTRL_OVF_CLR_B = 31;
   localparam int DEC_W          = 8;

   // A dec field of 0 behaves like 1 (every latched sample is kept).
   function automatic logic [DEC_W-1:0] dec_ratio(input logic [DEC_W-1:0] dec);
      return (dec == '0) ? DEC_W'(1) : dec;
   endfunction

endpackage

// File: rtl/pitch_fifo_mem.sv
// Single-clock FIFO storage: pointers, level, full/empty flags.
// Flush has priority over push and pop. A push while full is accepted only
// when a pop happens in the same cycle (the slot being vacated is reused).
module pitch_fifo_mem #(
   parameter int DATA_W  = 32,
   parameter int DEPTH_W = 4
) (
   input  logic              clk_i,
   input  logic              rst_n_i,
   input  logic              push_i,
   input  logic              pop_i,
   input  logic              flush_i,
   input  logic [DATA_W-1:0] data_i,
   output logic [DATA_W-1:0] head_o,
   output logic [DEPTH_W:0]  level_o,
   output logic              full_o,
   output logic              empty_o
);

   localparam int DEPTH = 1 << DEPTH_W;

   logic [DATA_W-1:0]  r_mem [DEPTH];
   logic [DEPTH_W-1:0] r_wr_ptr;
   logic [DEPTH_W-1:0] r_rd_ptr;
   logic [DEPTH_W:0]   r_level;
   logic               r_empty;

   logic               w_pop_ok;
   logic               w_push_ok;
   logic [DEPTH_W:0]   w_level_nxt;

   assign full_o   = r_level[DEPTH_W];
   assign empty_o  = r_empty;
   assign level_o  = r_level;
   assign head_o   = r_mem[r_rd_ptr];

   assign w_pop_ok  = pop_i && !r_empty;
   assign w_push_ok = push_i && (!full_o || w_pop_ok);

   // Next level from accepted push/pop; flush handled in the register.
   always_comb begin
      w_level_nxt = r_level;
      if (w_push_ok && !w_pop_ok) w_level_nxt = r_level + (DEPTH_W+1)'(1);
      if (!w_push_ok && w_pop_ok) w_level_nxt = r_level - (DEPTH_W+1)'(1);
   end

   // Pointer, level and registered empty flag update.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_level  <= '0;
         r_empty  <= 1'b1;
      end else if (flush_i) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_level  <= '0;
         r_empty  <= 1'b1;
      end else begin
         if (w_push_ok) r_wr_ptr <= r_wr_ptr + DEPTH_W'(1);
         if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + DEPTH_W'(1);
         r_level <= w_level_nxt;
         r_empty <= (w_level_nxt == '0);
      end
   end

   // Storage array; contents only matter behind valid pointers, so no reset.
   always_ff @(posedge clk_i) begin
      if (w_push_ok && !flush_i) r_mem[r_wr_ptr] <= data_i;
   end

endmodule

// File: rtl/pitch_smpl_fifo.sv
// Pitch sample FIFO: decimates latched pitch LPF samples, buffers them and
// serves them over rbus (data/pop register and status/control register).
// Optional macro PITCH_FIFO_DELTA_EN stores sample deltas instead of raw values.
module pitch_smpl_fifo
   import pitch_smpl_fifo_pkg::*;
#(
   parameter int                DATA_W    = 32,
   parameter int                ADDR_W    = 8,
   parameter int                DEPTH_W   = 4,
   parameter logic [ADDR_W-1:0] ADDR_DATA = 8'h40,
   parameter logic [ADDR_W-1:0] ADDR_STAT = 8'h41
) (
   input  logic              clk_i,
   input  logic              rst_n_i,
   input  logic [DATA_W-1:0] smpl_i,
   input  logic              ltch_i,
   input  logic [ADDR_W-1:0] rbus_addr_i,
   input  logic              rbus_wr_i,
   input  logic              rbus_rd_i,
   input  logic [DATA_W-1:0] rbus_wr_data_i,
   output logic [DATA_W-1:0] rbus_rd_data_o,
   output logic              irq_o
);

   logic [DEC_W-1:0]  r_dec;
   logic [DEC_W-1:0]  r_cnt;
   logic              r_ovf;
   logic [DATA_W-1:0] r_rd_data;

   logic              w_ctl_wr;
   logic              w_pop;
   logic              w_stat_rd;
   logic              w_flush;
   logic              w_ovf_clr;
   logic [DEC_W-1:0]  w_dec_new;
   logic [DEC_W-1:0]  w_cnt_base;
   logic [DEC_W-1:0]  w_cnt_nxt;
   logic              w_push_req;
   logic              w_drop;
   logic [DATA_W-1:0] w_push_data;
   logic [DATA_W-1:0] w_head;
   logic [DEPTH_W:0]  w_level;
   logic              w_full;
   logic              w_empty;
   logic [DATA_W-1:0] w_stat;
   logic              w_unused;

   assign w_ctl_wr  = rbus_wr_i && (rbus_addr_i == ADDR_STAT);
   assign w_pop     = rbus_rd_i && (rbus_addr_i == ADDR_DATA);
   assign w_stat_rd = rbus_rd_i && (rbus_addr_i == ADDR_STAT);
   assign w_flush   = w_ctl_wr && rbus_wr_data_i[CTRL_FLUSH_B];
   assign w_ovf_clr = w_ctl_wr && rbus_wr_data_i[CTRL_OVF_CLR_B];
   assign w_dec_new = w_ctl_wr ? rbus_wr_data_i[STAT_DEC_LSB +: DEC_W] : r_dec;
   assign w_unused  = &{1'b0, rbus_wr_data_i[30:16], rbus_wr_data_i[7:1]};

   // Decimation: a dec write restarts the count, and a strobe in that same
   // cycle is evaluated against the new ratio as its first strobe.
   always_comb begin
      w_cnt_base = w_ctl_wr ? '0 : r_cnt;
      w_push_req = 1'b0;
      w_cnt_nxt  = w_cnt_base;
      if (ltch_i) begin
         if (w_cnt_base == dec_ratio(w_dec_new) - DEC_W'(1)) begin
            w_push_req = 1'b1;
            w_cnt_nxt  = '0;
         end else begin
            w_cnt_nxt  = w_cnt_base + DEC_W'(1);
         end
      end
   end

   // A push is lost only when full, nothing leaves this cycle and no flush.
   assign w_drop = w_push_req && w_full && !w_pop && !w_flush;

`ifdef PITCH_FIFO_DELTA_EN
   logic [DATA_W-1:0] r_prev;

   assign w_push_data = smpl_i - r_prev;

   // Track the last decimated sample; flush restarts the delta chain at 0.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i)        r_prev <= '0;
      else if (w_flush)    r_prev <= '0;
      else if (w_push_req) r_prev <= smpl_i;
   end
`else
   assign w_push_data = smpl_i;
`endif

   pitch_fifo_mem #(
      .DATA_W  (DATA_W),
      .DEPTH_W (DEPTH_W)
   ) u_mem (
      .clk_i   (clk_i),
      .rst_n_i (rst_n_i),
      .push_i  (w_push_req),
      .pop_i   (w_pop),
      .flush_i (w_flush),
      .data_i  (w_push_data),
      .head_o  (w_head),
      .level_o (w_level),
      .full_o  (w_full),
      .empty_o (w_empty)
   );

   // Status word assembled from current state.
   always_comb begin
      w_stat                              = '0;
      w_stat[STAT_OVF_B]                  = r_ovf;
      w_stat[STAT_EMPTY_B]                = w_empty;
      w_stat[STAT_DEC_LSB +: DEC_W]       = r_dec;
      w_stat[DEPTH_W:0]                   = w_level;
   end

   // Control state: dec, decimation counter and sticky overflow.
   // A drop in the same cycle as a clear is the later event and wins.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         r_dec <= '0;
         r_cnt <= '0;
         r_ovf <= 1'b0;
      end else begin
         r_dec <= w_dec_new;
         r_cnt <= w_cnt_nxt;
         if (w_drop)         r_ovf <= 1'b1;
         else if (w_ovf_clr) r_ovf <= 1'b0;
      end
   end

   // Registered read data: one cycle after the read, zero otherwise.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i)       r_rd_data <= '0;
      else if (w_pop)     r_rd_data <= w_empty ? '0 : w_head;
      else if (w_stat_rd) r_rd_data <= w_stat;
      else                r_rd_data <= '0;
   end

   assign rbus_rd_data_o = r_rd_data;
   assign irq_o          = !w_empty;

endmodule

// File: tb/tb_pitch_smpl_fifo.sv
// Directed self-checking bench for pitch_smpl_fifo (default and
// PITCH_FIFO_DELTA_EN builds).
module tb_pitch_smpl_fifo;

   localparam logic [7:0] A_DATA = 8'h40;
   localparam logic [7:0] A_STAT = 8'h41;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [31:0] smpl = '0;
   logic        ltch = 1'b0;
   logic [7:0]  addr = '0;
   logic        wr = 1'b0;
   logic        rd = 1'b0;
   logic [31:0] wdata = '0;
   logic [31:0] rdata;
   logic        irq;

   int          total = 0;
   int          bad = 0;
   logic [31:0] tb_prev = '0;
   logic [31:0] d;
   logic [31:0] exp_q [16];

   pitch_smpl_fifo dut (
      .clk_i          (clk),
      .rst_n_i        (rst_n),
      .smpl_i         (smpl),
      .ltch_i         (ltch),
      .rbus_addr_i    (addr),
      .rbus_wr_i      (wr),
      .rbus_rd_i      (rd),
      .rbus_wr_data_i (wdata),
      .rbus_rd_data_o (rdata),
      .irq_o          (irq)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Expected stored value for a decimated sample.
   function automatic logic [31:0] enc(input logic [31:0] v);
`ifdef PITCH_FIFO_DELTA_EN
      enc = v - tb_prev;
      tb_prev = v;
`else
      enc = v;
`endif
   endfunction

   task automatic strobe(input logic [31:0] v);
      smpl = v; ltch = 1'b1;
      @(posedge clk); #1;
      ltch = 1'b0;
   endtask

   task automatic wreg(input logic [7:0] a, input logic [31:0] v);
      addr = a; wdata = v; wr = 1'b1;
      @(posedge clk); #1;
      wr = 1'b0;
   endtask

   task automatic rreg(input logic [7:0] a, output logic [31:0] v);
      addr = a; rd = 1'b1;
      @(posedge clk); #1;
      rd = 1'b0;
      v = rdata;
   endtask

   task automatic strobe_pop(input logic [31:0] s, output logic [31:0] v);
      smpl = s; ltch = 1'b1; addr = A_DATA; rd = 1'b1;
      @(posedge clk); #1;
      ltch = 1'b0; rd = 1'b0;
      v = rdata;
   endtask

   task automatic strobe_wreg(input logic [31:0] s, input logic [31:0] v);
      smpl = s; ltch = 1'b1; addr = A_STAT; wdata = v; wr = 1'b1;
      @(posedge clk); #1;
      ltch = 1'b0; wr = 1'b0;
   endtask

   initial begin
      // Reset
      #12;
      chk("rst_rdata", rdata, 32'h0);
      chk("rst_irq", {31'b0, irq}, 32'h0);
      rst_n = 1'b1;
      @(posedge clk); #1;
      rreg(A_STAT, d); chk("rst_stat", d, 32'h4000_0000);

      // dec=0: every strobe is kept
      strobe(100); strobe(200); strobe(300);
      exp_q[0] = enc(100); exp_q[1] = enc(200); exp_q[2] = enc(300);
      rreg(A_STAT, d); chk("t1_stat", d, 32'h0000_0003);
      chk("t1_irq", {31'b0, irq}, 32'h1);
      for (int i = 0; i < 3; i++) begin
         rreg(A_DATA, d); chk($sformatf("t1_pop%0d", i), d, exp_q[i]);
      end
      @(posedge clk); #1;
      chk("t1_idle_zero", rdata, 32'h0);
      rreg(A_DATA, d); chk("t1_pop_empty", d, 32'h0);
      chk("t1_irq_off", {31'b0, irq}, 32'h0);
      rreg(A_STAT, d); chk("t1_stat_empty", d, 32'h4000_0000);

      // dec=4: keep strobes 4, 8, 12
      wreg(A_STAT, 32'h0000_0400);
      for (int i = 1; i <= 12; i++) strobe(i);
      exp_q[0] = enc(4); exp_q[1] = enc(8); exp_q[2] = enc(12);
      rreg(A_STAT, d); chk("t2_stat", d, 32'h0000_0403);
      for (int i = 0; i < 3; i++) begin
         rreg(A_DATA, d); chk($sformatf("t2_pop%0d", i), d, exp_q[i]);
      end

      // dec=1: overfill by one
      wreg(A_STAT, 32'h0000_0100);
      for (int i = 1; i <= 17; i++) begin
         strobe(i);
         if (i <= 16) exp_q[i-1] = enc(i);
         else d = enc(i);
      end
      rreg(A_STAT, d); chk("t3_stat_full_ovf", d, 32'h8000_0110);
      wreg(A_STAT, 32'h8000_0100);
      rreg(A_STAT, d); chk("t3_stat_ovf_clr", d, 32'h0000_0110);
      for (int i = 0; i < 16; i++) begin
         rreg(A_DATA, d); chk($sformatf("t3_pop%0d", i), d, exp_q[i]);
      end
      rreg(A_STAT, d); chk("t3_stat_drained", d, 32'h4000_0100);

      // Full with same-cycle pop and push
      for (int i = 0; i < 16; i++) begin
         strobe(201 + i);
         exp_q[i] = enc(201 + i);
      end
      strobe_pop(99, d); chk("t4_pop_head", d, exp_q[0]);
      for (int i = 0; i < 15; i++) exp_q[i] = exp_q[i+1];
      exp_q[15] = enc(99);
      rreg(A_STAT, d); chk("t4_stat", d, 32'h0000_0110);
      for (int i = 0; i < 16; i++) begin
         rreg(A_DATA, d); chk($sformatf("t4_pop%0d", i), d, exp_q[i]);
      end

      // Flush with a same-cycle strobe
      for (int i = 0; i < 5; i++) d = enc(51 + i);
      for (int i = 0; i < 5; i++) strobe(51 + i);
      rreg(A_STAT, d); chk("t5_stat_pre", d, 32'h0000_0105);
      strobe_wreg(56, 32'h0000_0101);
      tb_prev = '0;
      chk("t5_irq", {31'b0, irq}, 32'h0);
      rreg(A_STAT, d); chk("t5_stat_flushed", d, 32'h4000_0100);

      // Delta chain (raw values when the option is off)
      strobe(1000); strobe(1010); strobe(990);
      rreg(A_DATA, d); chk("t6_pop0", d, 32'd1000);
`ifdef PITCH_FIFO_DELTA_EN
      rreg(A_DATA, d); chk("t6_pop1", d, 32'd10);
      rreg(A_DATA, d); chk("t6_pop2", d, 32'hFFFF_FFEC);
      tb_prev = 32'd990;
`else
      rreg(A_DATA, d); chk("t6_pop1", d, 32'd1010);
      rreg(A_DATA, d); chk("t6_pop2", d, 32'd990);
`endif

      // Empty with same-cycle pop and push
      strobe_pop(77, d); chk("t7_pop_empty", d, 32'h0);
      exp_q[0] = enc(77);
      rreg(A_STAT, d); chk("t7_stat", d, 32'h0000_0101);
      chk("t7_irq", {31'b0, irq}, 32'h1);
      rreg(A_DATA, d); chk("t7_pop", d, exp_q[0]);

      // Writes to the data address are ignored
      wreg(A_DATA, 32'h0000_0001);
      rreg(A_STAT, d); chk("t8_stat", d, 32'h4000_0100);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
